// File: rtl/remote_comm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | remote_comm_pkg                                                    |
// | Shared types and constants for the remote_comm UART bridge.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package remote_comm_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 2604;
  localparam logic [7:0]  RESP_POS_ACK     = 8'hA5;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_HIGH = 2'd1,
    CMD_LOW  = 2'd2
  } cmd_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_BUSY = 1'b1
  } rx_state_e;

  // 8N1 frame in shift order: start bit in [0], stop bit in [9].
  function automatic logic [9:0] uart_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/remote_comm_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | remote_comm_if                                                     |
// | Host-side command/response handshake of the remote_comm bridge.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface remote_comm_if;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;

  modport master (
    output cmd,
    output send_cmd,
    input  cmd_sent,
    input  resp,
    input  resp_rdy
  );

  modport slave (
    input  cmd,
    input  send_cmd,
    output cmd_sent,
    output resp,
    output resp_rdy
  );
endinterface
`default_nettype wire

// File: rtl/remote_comm_uart.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | remote_comm_uart                                                   |
// | Independent 8N1 transmitter and receiver, BAUD_DIV clocks per bit. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module remote_comm_uart
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic       TX,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       clr_rdy
);

  localparam int unsigned    CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  // ---------------- transmitter ----------------
  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_baud_q;
  logic [3:0]    tx_bit_q;
  logic [9:0]    tx_shift_q;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_state_q == TX_BUSY) && (tx_baud_q == BAUD_LAST);
  assign tx_done    = tx_bit_end && (tx_bit_q == 4'd9);
  // Idle shifter is all ones, so the line idles high straight from the register.
  assign TX         = tx_shift_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else if (trmt) begin
      tx_state_q <= TX_BUSY;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= uart_frame(tx_data);
    end else if (tx_state_q == TX_BUSY) begin
      if (tx_bit_end) begin
        tx_baud_q  <= '0;
        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        if (tx_bit_q == 4'd9) begin
          tx_state_q <= TX_IDLE;
          tx_bit_q   <= '0;
        end else begin
          tx_bit_q <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_baud_q <= tx_baud_q + CW'(1);
      end
    end
  end

  // ---------------- receiver ----------------
  logic          rx_ff1_q;
  logic          rx_sync_q;
  logic          rx_prev_q;
  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_baud_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_rdy_q;
  logic          rx_start;
  logic          rx_sample;
  logic          rx_set;

  assign rx_start  = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;
  assign rx_sample = (rx_state_q == RX_BUSY) && (rx_baud_q == '0);
  assign rx_set    = rx_sample && (rx_bit_q == 4'd9);
  assign rx_data   = rx_data_q;
  assign rx_rdy    = rx_rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ff1_q  <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_ff1_q  <= RX;
      rx_sync_q <= rx_ff1_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Count down to each sample point; a high start sample means the edge was a glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_start) begin
            rx_state_q <= RX_BUSY;
            rx_baud_q  <= HALF_LAST;
            rx_bit_q   <= '0;
          end
        end
        RX_BUSY: begin
          if (rx_baud_q != '0) begin
            rx_baud_q <= rx_baud_q - CW'(1);
          end else if ((rx_bit_q == 4'd0 && rx_sync_q) || rx_bit_q == 4'd9) begin
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
          end else begin
            rx_baud_q <= BAUD_LAST;
            rx_bit_q  <= rx_bit_q + 4'd1;
            if (rx_bit_q != 4'd0) begin
              rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q <= '0;
      rx_rdy_q  <= 1'b0;
    end else if (rx_set) begin
      rx_data_q <= rx_shift_q;
      rx_rdy_q  <= 1'b1;
    end else if (clr_rdy || rx_start) begin
      rx_rdy_q  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/remote_comm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | remote_comm                                                        |
// | Sends a 16-bit command as two UART bytes (high first), returns     |
// | received response bytes.                                           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RX,
  output logic          TX,
  remote_comm_if.slave  bus
);

  cmd_state_e state_q;
  logic [7:0] low_byte_q;
  logic       cmd_sent_q;
  logic       accept;
  logic       trmt;
  logic       tx_done;
  logic [7:0] tx_data;

  assign accept       = (state_q == CMD_IDLE) && bus.send_cmd;
  // Low byte is launched in the same cycle the high byte's stop bit ends.
  assign trmt         = accept || ((state_q == CMD_HIGH) && tx_done);
  assign tx_data      = (state_q == CMD_IDLE) ? bus.cmd[15:8] : low_byte_q;
  assign bus.cmd_sent = cmd_sent_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CMD_IDLE;
      low_byte_q <= '0;
      cmd_sent_q <= 1'b0;
    end else begin
      case (state_q)
        CMD_IDLE: begin
          if (bus.send_cmd) begin
            low_byte_q <= bus.cmd[7:0];
            cmd_sent_q <= 1'b0;
            state_q    <= CMD_HIGH;
          end
        end
        CMD_HIGH: begin
          if (tx_done) state_q <= CMD_LOW;
        end
        CMD_LOW: begin
          if (tx_done) begin
            cmd_sent_q <= 1'b1;
            state_q    <= CMD_IDLE;
          end
        end
        default: state_q <= CMD_IDLE;
      endcase
    end
  end

  remote_comm_uart #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .TX      (TX),
    .tx_data (tx_data),
    .trmt    (trmt),
    .tx_done (tx_done),
    .rx_data (bus.resp),
    .rx_rdy  (bus.resp_rdy),
    .clr_rdy (accept)
  );

endmodule
`default_nettype wire

// File: tb/tb_remote_comm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_remote_comm                                                     |
// | Self-checking bench: line-level UART decoder and expected queues.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_remote_comm;

  localparam int BD = 16;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic rx_drv  = 1'b1;
  logic loop_en = 1'b0;
  logic tx_line;
  logic rx_line;

  always #5 clk = ~clk;

  remote_comm_if bus();
  assign rx_line = loop_en ? tx_line : rx_drv;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .RX  (rx_line),
    .TX  (tx_line),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_resp[$];
  bit mon_en       = 1'b0;
  int last_start   = -1000;
  int last_end     = -1000;
  int n_frames     = 0;
  int n_sent_rises = 0;
  int n_resp_rises = 0;
  int last_fall    = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Decodes every frame on TX by mid-bit sampling and matches it to the expected byte stream.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx_line === 1'b0) begin : frame
        int p;
        logic [7:0] b;
        p = cyc;
        if (n_frames % 2 == 1) check("byte_gap", (p >= last_end) && (p - last_end <= 2), 1);
        last_start = p;
        last_end   = p + 10 * BD;
        repeat (BD / 2) @(negedge clk);
        check("tx_start_bit", tx_line, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = tx_line;
        end
        repeat (BD) @(negedge clk);
        check("tx_stop_bit", tx_line, 1);
        check("tx_byte_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) check("tx_byte", b, exp_tx.pop_front());
        n_frames++;
      end
    end
  end

  initial begin
    logic ps;
    logic pr;
    ps = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (!ps && bus.cmd_sent === 1'b1) begin
        n_sent_rises++;
        if (mon_en) check("sent_latency", (cyc >= last_end) && (cyc - last_end <= 2), 1);
      end
      if (!pr && bus.resp_rdy === 1'b1) begin
        n_resp_rises++;
        check("resp_expected", exp_resp.size() > 0, 1);
        if (exp_resp.size() > 0) check("resp", bus.resp, exp_resp.pop_front());
      end
      if (pr && bus.resp_rdy === 1'b0) last_fall = cyc;
      ps = bus.cmd_sent;
      pr = bus.resp_rdy;
    end
  end

  task automatic send(input logic [15:0] c, input bit expect_bytes);
    @(negedge clk);
    bus.cmd      = c;
    bus.send_cmd = 1'b1;
    if (expect_bytes) begin
      exp_tx.push_back(c[15:8]);
      exp_tx.push_back(c[7:0]);
    end
    @(negedge clk);
    bus.send_cmd = 1'b0;
  endtask

  task automatic wait_sent(input string tag);
    int k;
    k = 0;
    while (bus.cmd_sent !== 1'b1 && k < 30 * BD) begin
      @(negedge clk);
      k++;
    end
    check(tag, bus.cmd_sent, 1);
  endtask

  task automatic drive_rx(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    exp_resp.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      repeat (BD) @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int r0;
    bit seen;
    logic [7:0] rb;
    bus.cmd      = '0;
    bus.send_cmd = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx", tx_line, 1);
    check("rst_cmd_sent", bus.cmd_sent, 0);
    check("rst_resp_rdy", bus.resp_rdy, 0);
    check("rst_resp", bus.resp, 8'h00);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx_line !== 1'b1) seen = 1'b1;
    end
    check("idle_tx_high", seen, 0);
    mon_en = 1'b1;

    s0 = n_sent_rises;
    send(16'h2000, 1'b1);
    wait_sent("sent_2000");
    repeat (5) @(negedge clk);
    check("sent_2000_once", n_sent_rises - s0, 1);

    loop_en = 1'b1;
    r0 = n_resp_rises;
    exp_resp.push_back(8'hA5);
    exp_resp.push_back(8'h5A);
    send(16'hA55A, 1'b1);
    wait_sent("sent_loop");
    repeat (20) @(negedge clk);
    check("loop_resp_count", n_resp_rises - r0, 2);
    check("rdy_drop_at_start", (last_fall >= last_start) && (last_fall - last_start <= 4), 1);
    loop_en = 1'b0;

    s0 = n_sent_rises;
    send(16'h1234, 1'b1);
    repeat (40) @(negedge clk);
    send(16'hFFFF, 1'b0);
    wait_sent("sent_busy");
    repeat (200) @(negedge clk);
    check("busy_sent_once", n_sent_rises - s0, 1);
    check("busy_sent_held", bus.cmd_sent, 1);

    r0 = n_resp_rises;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_rdy", n_resp_rises - r0, 0);
    drive_rx(8'hA5);
    repeat (20) @(negedge clk);
    check("after_glitch_rx", n_resp_rises - r0, 1);
    check("after_glitch_resp", bus.resp, 8'hA5);

    for (int t = 0; t < 6; t++) begin : dup
      logic [15:0] c;
      logic [7:0]  b;
      int d;
      c  = 16'($urandom);
      b  = 8'($urandom);
      d  = $urandom_range(0, 150);
      s0 = n_sent_rises;
      r0 = n_resp_rises;
      fork
        begin
          send(c, 1'b1);
          wait_sent("sent_dup");
        end
        begin
          repeat (d) @(negedge clk);
          drive_rx(b);
        end
      join
      repeat (30) @(negedge clk);
      check("dup_sent_once", n_sent_rises - s0, 1);
      check("dup_resp_once", n_resp_rises - r0, 1);
    end

    mon_en = 1'b0;
    s0 = n_sent_rises;
    rb = 8'h4E;
    send(16'h4E00, 1'b0);
    repeat (5 * BD + BD / 2) @(negedge clk);
    check("pre_rst_tx_bit4", tx_line, rb[4]);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx_line, 1);
    check("mid_rst_cmd_sent", bus.cmd_sent, 0);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("aborted_no_sent", n_sent_rises - s0, 0);
    check("aborted_tx_idle", tx_line, 1);
    mon_en = 1'b1;
    send(16'hC3A1, 1'b1);
    wait_sent("sent_after_rst");
    repeat (20) @(negedge clk);

    check("tx_queue_drained", exp_tx.size(), 0);
    check("resp_queue_drained", exp_resp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
